// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the pipeline registers
// that follow it.
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // sll $0,$0,0 -- the architectural NOP loaded into a bubbled IF/ID slot
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_MASK        = 32'h0000_0003;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~WORD_MASK;
  endfunction

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: the fetch stage is master, the memory is slave.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, and an idle
// cycle with nothing to load inserts a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            write_en,
  input  logic            load,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr_r,
  output logic [XLEN-1:0] pc_plus4_r,
  output logic            valid_r
);

  // Pipeline register update with flush/hold/load/bubble priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else if (flush) begin
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end else if (!write_en) begin
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
      valid_r    <= valid_r;
    end else if (load) begin
      instr_r    <= instr;
      pc_plus4_r <= pc_plus4;
      valid_r    <= 1'b1;
    end else begin
      instr_r    <= NOP_INSTR;
      pc_plus4_r <= 32'h0000_0000;
      valid_r    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, reads instruction memory over a
// req/ready handshake and feeds the IF/ID register, parking late redirects.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             PCWrite,
  input  logic             IF_ID_Write,
  input  logic             IF_ID_flush,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  fetch_stage_if.master    imem,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  IF_ID_Instruction,
  output logic [XLEN-1:0]  IF_ID_PCPlus4,
  output logic             IF_ID_Valid
);

  fetch_state_e    state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pend_target_r;

  logic            req_s;
  logic            transfer_s;
  logic            redirect_s;
  logic            accept_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] pc_plus4_s;

  // Handshake decode; a redirect only counts when the PC is allowed to move
  always_comb begin
    req_s      = (state_r != ST_IDLE);
    transfer_s = req_s & imem.imem_ready;
    redirect_s = redirect_valid & PCWrite;
    target_s   = word_align(redirect_target);
    pc_plus4_s = pc_plus4(pc_r);
    accept_s   = (state_r == ST_FETCH) & transfer_s & PCWrite & ~redirect_valid;
  end

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = pc_r;
  assign PC             = pc_r;

  // Fetch FSM: PC only moves on a completed transfer, so the request address
  // stays stable while the memory is busy
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      pend_target_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_FETCH;
        end
        ST_FETCH: begin
          if (redirect_s) begin
            if (transfer_s) begin
              pc_r <= target_s;
            end else begin
              pend_target_r <= target_s;
              state_r       <= ST_DISCARD;
            end
          end else if (accept_s) begin
            pc_r <= pc_plus4_s;
          end else begin
            pc_r <= pc_r;
          end
        end
        ST_DISCARD: begin
          // The stale word is dropped; the newest redirect target wins
          if (transfer_s) begin
            pc_r    <= redirect_s ? target_s : pend_target_r;
            state_r <= ST_FETCH;
          end else if (redirect_s) begin
            pend_target_r <= target_s;
          end else begin
            pend_target_r <= pend_target_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .flush      (IF_ID_flush),
    .write_en   (IF_ID_Write),
    .load       (accept_s),
    .instr      (imem.imem_rdata),
    .pc_plus4   (pc_plus4_s),
    .instr_r    (IF_ID_Instruction),
    .pc_plus4_r (IF_ID_PCPlus4),
    .valid_r    (IF_ID_Valid)
  );

endmodule
